// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with occupancy count, threshold flags, sticky errors, flush and optional FWFT read
module fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int SIZE     = 32,
  parameter int LOG_SIZE = 5,
  parameter int AF_LEVEL = SIZE - 4,
  parameter int AE_LEVEL = 4,
  parameter bit FWFT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    data_w,
  input  logic                we,
  input  logic                re,
  input  logic                flush,
  output logic [WIDTH-1:0]    data_r,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [LOG_SIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);
  localparam logic [LOG_SIZE:0]   CNT_ONE = (LOG_SIZE+1)'(1);
  localparam logic [LOG_SIZE-1:0] PTR_ONE = LOG_SIZE'(1);
  logic [WIDTH-1:0]    mem [SIZE];
  logic [LOG_SIZE-1:0] wr_ptr, rd_ptr;
  logic                wr_ok, rd_ok, run;
  assign run          = rst_n && !flush;
  assign wr_ok        = we && !full;
  assign rd_ok        = re && !empty;
  assign empty        = count == '0;
  assign full         = count == (LOG_SIZE+1)'(SIZE);
  assign almost_empty = count <= (LOG_SIZE+1)'(AE_LEVEL);
  assign almost_full  = count >= (LOG_SIZE+1)'(AF_LEVEL);
  // pointers, occupancy and sticky error flags; reset beats flush beats normal traffic
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ok ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr    <= rd_ok ? rd_ptr + PTR_ONE : rd_ptr;
      count     <= (wr_ok && !rd_ok) ? count + CNT_ONE :
                   (rd_ok && !wr_ok) ? count - CNT_ONE : count;
      overflow  <= overflow || (we && full);
      underflow <= underflow || (re && empty);
    end
  end
  // storage has no reset; writes are suppressed during reset and flush
  always_ff @(posedge clk) begin
    if (run && wr_ok) mem[wr_ptr] <= data_w;
  end
  generate
    if (FWFT) begin : g_fwft
      assign data_r = mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] q;
      // registered read port: loads on an accepted read, holds through flush
      always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else if (!flush && rd_ok) q <= mem[rd_ptr];
      end
      assign data_r = q;
    end
  endgenerate
endmodule
